// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target answering 0x03/0x0B reads from a byte-wide memory port.
// SPI pins are oversampled in the clock domain; one-byte prefetch with a single outstanding fetch.
module spi_flash_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_BITS   = 24
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 spi_csn,
  input  logic                 spi_sclk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  output logic                 mem_req,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_rdata,
  output logic                 active,
  output logic [7:0]           last_cmd,
  output logic                 underrun
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] csn_sync, sclk_sync, mosi_sync;
  logic                   csn_s, sclk_s, mosi_s, csn_q, sclk_q;
  logic                   sck_rise, sck_fall, csn_fall;

  logic [4:0]             cnt;
  logic [2:0]             bitpos;
  logic [22:0]            sr_in;
  logic                   fast;
  logic [ADDR_BITS-1:0]   addr_cnt;
  logic [7:0]             sr_out;
  logic                   buf_valid;
  logic [7:0]             buf_data;
  logic                   want, discard;
  logic [ADDR_BITS-1:0]   want_addr;

  logic                   abort, shift_in, cnt_inc, cnt_clr, cmd_done, addr_done, byte_load, bit_shift;
  logic [7:0]             opcode, load_byte;
  logic [23:0]            addr_word;
  logic                   fetch_go, req_done;
  logic [ADDR_BITS-1:0]   fetch_a;

  always_ff @(posedge clock) begin
    if (reset) begin
      csn_sync  <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      csn_q     <= 1'b1;
      sclk_q    <= 1'b0;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      csn_q     <= csn_s;
      sclk_q    <= sclk_s;
    end
  end

  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sck_rise  = sclk_s & ~sclk_q;
  assign sck_fall  = ~sclk_s & sclk_q;
  assign csn_fall  = ~csn_s & csn_q;

  assign opcode    = {sr_in[6:0], mosi_s};
  assign addr_word = {sr_in, mosi_s};
  assign active    = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // CSN high outranks any SCK edge seen in the same cycle.
  always_comb begin
    state_n   = state;
    abort     = 1'b0;
    shift_in  = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    cmd_done  = 1'b0;
    addr_done = 1'b0;
    byte_load = 1'b0;
    bit_shift = 1'b0;
    if (state != IDLE && csn_s) begin
      state_n = IDLE;
      abort   = 1'b1;
    end else begin
      case (state)
        IDLE: if (csn_fall) begin
          state_n = CMD;
          cnt_clr = 1'b1;
        end
        CMD: if (sck_rise) begin
          shift_in = 1'b1;
          if (cnt == 5'd7) begin
            cmd_done = 1'b1;
            cnt_clr  = 1'b1;
            state_n  = (opcode == 8'h03 || opcode == 8'h0B) ? ADDR : IGNORE;
          end else cnt_inc = 1'b1;
        end
        ADDR: if (sck_rise) begin
          shift_in = 1'b1;
          if (cnt == 5'd23) begin
            addr_done = 1'b1;
            cnt_clr   = 1'b1;
            state_n   = fast ? DUMMY : DATA;
          end else cnt_inc = 1'b1;
        end
        DUMMY: if (sck_rise) begin
          if (cnt == 5'd7) begin
            cnt_clr = 1'b1;
            state_n = DATA;
          end else cnt_inc = 1'b1;
        end
        DATA: if (sck_fall) begin
          if (bitpos == 3'd0) byte_load = 1'b1;
          else                bit_shift = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign load_byte = buf_valid ? buf_data : 8'hFF;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      bitpos      <= '0;
      sr_in       <= '0;
      fast        <= 1'b0;
      last_cmd    <= 8'h00;
      addr_cnt    <= '0;
      sr_out      <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 5'd1;
      if (cnt_clr)                     bitpos <= '0;
      else if (byte_load || bit_shift) bitpos <= bitpos + 3'd1;
      if (shift_in) sr_in <= {sr_in[21:0], mosi_s};
      if (cmd_done) begin
        last_cmd <= opcode;
        fast     <= (opcode == 8'h0B);
      end
      if (addr_done)      addr_cnt <= addr_word[ADDR_BITS-1:0];
      else if (byte_load) addr_cnt <= addr_cnt + 1'b1;
      if (abort) begin
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else if (byte_load) begin
        spi_miso    <= load_byte[7];
        sr_out      <= {load_byte[6:0], 1'b0};
        spi_miso_oe <= 1'b1;
      end else if (bit_shift) begin
        spi_miso <= sr_out[7];
        sr_out   <= {sr_out[6:0], 1'b0};
      end
      if (byte_load && !buf_valid) underrun <= 1'b1;
    end
  end

  // An underrun load issues no fetch: the request already in flight refills the buffer.
  assign fetch_go = addr_done | (byte_load & buf_valid);
  assign fetch_a  = addr_done ? addr_word[ADDR_BITS-1:0] : addr_cnt + 1'b1;
  assign req_done = mem_req & mem_ack;

  // A fetch that finds the port busy (e.g. a discarded request from the last
  // transaction) is parked in want/want_addr until the port frees up.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      want      <= 1'b0;
      want_addr <= '0;
      discard   <= 1'b0;
      buf_valid <= 1'b0;
      buf_data  <= 8'h00;
    end else begin
      if (req_done) begin
        mem_req <= 1'b0;
        discard <= 1'b0;
      end else if (!mem_req && want && !abort) begin
        mem_req  <= 1'b1;
        mem_addr <= want_addr;
        want     <= 1'b0;
      end
      if (fetch_go) begin
        if (!mem_req && !want) begin
          mem_req  <= 1'b1;
          mem_addr <= fetch_a;
        end else begin
          want      <= 1'b1;
          want_addr <= fetch_a;
        end
      end
      if (abort) begin
        want    <= 1'b0;
        discard <= mem_req & ~mem_ack;
      end
      if (abort) buf_valid <= 1'b0;
      else if (req_done && !discard) begin
        buf_valid <= 1'b1;
        buf_data  <= mem_rdata;
      end else if (fetch_go) buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: SPI master tasks, latency-controlled memory,
// and an address/data model derived from the read-command rules.
module tb_spi_flash_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        spi_csn, spi_sclk, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic        mem_req, mem_ack;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        active, underrun;
  logic [7:0]  last_cmd;

  int n_tests = 0;
  int n_fail  = 0;
  int hp      = 10;
  int ack_lat = 2;
  int oe_cnt  = 0;
  int req_cnt = 0;
  logic exp_under = 1'b0;
  logic [23:0] addr_log[$];

  spi_flash_responder dut (
    .clock(clock), .reset(reset),
    .spi_csn(spi_csn), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .active(active), .last_cmd(last_cmd), .underrun(underrun)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] model_byte(input logic [23:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Memory: acks each request ack_lat cycles after it is seen.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clock);
      if (mem_req === 1'b1 && reset === 1'b0) begin
        addr_log.push_back(mem_addr);
        repeat (ack_lat) @(negedge clock);
        mem_ack   = 1'b1;
        mem_rdata = model_byte(mem_addr);
        @(negedge clock);
        mem_ack   = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (spi_miso_oe === 1'b1) oe_cnt <= oe_cnt + 1;
    if (mem_req === 1'b1)     req_cnt <= req_cnt + 1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One bit: SCK falls, MOSI set, MISO sampled just before the rise; SCK left high.
  task automatic sck_bit(input logic mo, output logic mi);
    spi_sclk = 1'b0;
    spi_mosi = mo;
    repeat (hp) @(negedge clock);
    mi = spi_miso;
    spi_sclk = 1'b1;
    repeat (hp) @(negedge clock);
  endtask

  task automatic xfer_byte(input logic [7:0] mo, output logic [7:0] mi);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      sck_bit(mo[i], b);
      mi[i] = b;
    end
  endtask

  task automatic cs_low();
    spi_csn = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic cs_high();
    spi_csn = 1'b1;
    repeat (4) @(negedge clock);
    spi_sclk = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic run_read(input logic [7:0] op, input logic [23:0] a, input int n, input string tag);
    logic [7:0]  rx;
    logic [23:0] ea;
    int base, oe0;
    base = addr_log.size();
    cs_low();
    xfer_byte(op, rx);
    xfer_byte(a[23:16], rx);
    xfer_byte(a[15:8], rx);
    xfer_byte(a[7:0], rx);
    if (op == 8'h0B) begin
      oe0 = oe_cnt;
      xfer_byte(8'hFF, rx);
      chk({tag, " dummy_oe_cycles"}, 32'(oe_cnt - oe0), 32'd0);
    end
    for (int i = 0; i < n; i++) begin
      ea = a + 24'(i);
      xfer_byte(8'h00, rx);
      chk($sformatf("%s byte%0d", tag, i), 32'(rx), 32'(model_byte(ea)));
    end
    chk({tag, " oe_on"}, 32'(spi_miso_oe), 32'd1);
    chk({tag, " active_on"}, 32'(active), 32'd1);
    cs_high();
    chk({tag, " oe_off"}, 32'(spi_miso_oe), 32'd0);
    chk({tag, " miso_off"}, 32'(spi_miso), 32'd0);
    chk({tag, " active_off"}, 32'(active), 32'd0);
    chk({tag, " fetch_count"}, 32'(addr_log.size() - base), 32'(n + 1));
    for (int i = 0; i <= n; i++) begin
      ea = a + 24'(i);
      if (base + i < addr_log.size())
        chk($sformatf("%s addr%0d", tag, i), 32'(addr_log[base + i]), 32'(ea));
    end
    chk({tag, " last_cmd"}, 32'(last_cmd), 32'(op));
    chk({tag, " underrun"}, 32'(underrun), 32'(exp_under));
  endtask

  initial begin
    logic [7:0]  rx, op;
    logic [23:0] a;
    logic        b;
    int          n, oe0, rq0, base;

    reset = 1'b1; spi_csn = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst miso", 32'(spi_miso), 32'd0);
    chk("rst oe", 32'(spi_miso_oe), 32'd0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst active", 32'(active), 32'd0);
    chk("rst last_cmd", 32'(last_cmd), 32'd0);
    chk("rst underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    run_read(8'h03, 24'h000010, 4, "t1");
    run_read(8'h0B, 24'h200000, 2, "t2");
    run_read(8'h03, 24'hFFFFFE, 3, "t3");

    for (int t = 0; t < 6; t++) begin
      op      = ($urandom_range(0, 1) == 1) ? 8'h0B : 8'h03;
      a       = 24'($urandom);
      if (t == 0) a = 24'hFFFFFD;
      n       = int'($urandom_range(1, 4));
      hp      = int'($urandom_range(10, 14));
      ack_lat = int'($urandom_range(0, 3));
      run_read(op, a, n, $sformatf("rnd%0d", t));
    end
    hp = 10; ack_lat = 2;

    // Unsupported opcode: no fetch, no drive.
    oe0 = oe_cnt; rq0 = req_cnt; base = addr_log.size();
    cs_low();
    xfer_byte(8'h9F, rx);
    xfer_byte(8'h00, rx);
    xfer_byte(8'h00, rx);
    spi_csn = 1'b1;
    repeat (2) @(negedge clock);
    chk("t4 active_held", 32'(active), 32'd1);
    @(negedge clock);
    chk("t4 active_drop", 32'(active), 32'd0);
    spi_sclk = 1'b0;
    repeat (10) @(negedge clock);
    chk("t4 oe_cycles", 32'(oe_cnt - oe0), 32'd0);
    chk("t4 req_cycles", 32'(req_cnt - rq0), 32'd0);
    chk("t4 fetches", 32'(addr_log.size() - base), 32'd0);
    chk("t4 last_cmd", 32'(last_cmd), 32'h9F);

    // Slow memory: first byte underruns.
    hp = 6; ack_lat = 40;
    cs_low();
    xfer_byte(8'h03, rx);
    xfer_byte(8'h00, rx);
    xfer_byte(8'h01, rx);
    xfer_byte(8'h00, rx);
    xfer_byte(8'h00, rx);
    chk("t5 byte0", 32'(rx), 32'hFF);
    chk("t5 underrun", 32'(underrun), 32'd1);
    cs_high();
    repeat (60) @(negedge clock);
    hp = 10; ack_lat = 2; exp_under = 1'b1;
    run_read(8'h03, 24'h000200, 2, "t5 after");

    // Abort after 3 data bits, CSN and SCK fall together.
    a = 24'h000033;
    cs_low();
    xfer_byte(8'h03, rx);
    xfer_byte(a[23:16], rx);
    xfer_byte(a[15:8], rx);
    xfer_byte(a[7:0], rx);
    rx = model_byte(a);
    for (int i = 0; i < 3; i++) begin
      sck_bit(1'b0, b);
      chk($sformatf("t6 bit%0d", i), 32'(b), 32'(rx[7 - i]));
    end
    spi_sclk = 1'b0;
    spi_csn  = 1'b1;
    repeat (4) @(negedge clock);
    chk("t6 oe_off", 32'(spi_miso_oe), 32'd0);
    chk("t6 miso_off", 32'(spi_miso), 32'd0);
    chk("t6 active_off", 32'(active), 32'd0);
    repeat (10) @(negedge clock);

    // Reset in the middle of a command.
    cs_low();
    rx = 8'hAB;
    for (int i = 0; i < 4; i++) sck_bit(rx[7 - i], b);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("t6 rst miso", 32'(spi_miso), 32'd0);
    chk("t6 rst oe", 32'(spi_miso_oe), 32'd0);
    chk("t6 rst mem_req", 32'(mem_req), 32'd0);
    chk("t6 rst mem_addr", 32'(mem_addr), 32'd0);
    chk("t6 rst active", 32'(active), 32'd0);
    chk("t6 rst last_cmd", 32'(last_cmd), 32'd0);
    chk("t6 rst underrun", 32'(underrun), 32'd0);
    spi_csn = 1'b1; spi_sclk = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("t6 post mem_req", 32'(mem_req), 32'd0);
    chk("t6 post active", 32'(active), 32'd0);
    chk("t6 post oe", 32'(spi_miso_oe), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- SPI-mode-0 flash target. It answers the flash read loader's read commands from a byte-wide backing memory port.
- Used in simulation and in loopback boards as a stand-in for the configuration flash that stores cartridge images (image base 0x200000, index stride 0x40000, flags word last).
- SPI pins are oversampled in the `clock` domain. No SCK-domain logic.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on spi_csn, spi_sclk and spi_mosi.
- ADDR_BITS, 24, width of the flash byte address; the address wraps modulo 2^ADDR_BITS.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- spi_csn  in  1  chip select, active low.
- spi_sclk  in  1  SPI clock, idle low. Minimum high/low time is SYNC_STAGES+4+mem latency clocks.
- spi_mosi  in  1  command/address data, sampled on SCK rising edge.
- spi_miso  out  1  read data, MSB first, changes after SCK falling edge.
- spi_miso_oe  out  1  high only while driving read data.
- mem_req  out  1  byte fetch request, held until mem_ack.
- mem_addr  out  ADDR_BITS  byte address of the fetch, stable while mem_req is high.
- mem_ack  in  1  one-cycle pulse; mem_rdata is valid in the same cycle.
- mem_rdata  in  8  fetched byte.
- active  out  1  high from synced CSN low to synced CSN high.
- last_cmd  out  8  opcode of the most recent command byte received.
- underrun  out  1  sticky; set when a data byte is needed and the prefetch is not valid.

Behaviour:
- Input handling: 2-flop (SYNC_STAGES) synchronizers, then edge detect on synced SCK. A rise pulse or fall pulse lasts one clock.
- Reset values: spi_miso=0, spi_miso_oe=0, mem_req=0, mem_addr=0, active=0, last_cmd=0x00, underrun=0. State=IDLE; prefetch invalid.
- Reset mid-transfer forces IDLE and drops any outstanding request.
- IDLE:
  - On synced CSN fall: clear bit counter, active=1, go to CMD.
  - SCK edges while CSN is high are ignored.
- CMD: shift 8 bits on rise. On the 8th rise, latch last_cmd and dispatch:
  - 0x03 read → ADDR.
  - 0x0B fast read → ADDR.
  - 0xAB release power-down → IGNORE.
  - Any other opcode → IGNORE.
- ADDR: shift 24 bits MSB first; the low ADDR_BITS bits are used. On the 24th rise:
  - Load the address counter.
  - Assert mem_req with mem_addr equal to that address.
  - Next state: 0x03 → DATA; 0x0B → DUMMY.
- DUMMY: count 8 rises, ignore MOSI, then go to DATA.
- DATA:
  - On each fall at bit position 0, load the shift register from the prefetch buffer and drive bit 7.
  - Immediately issue the next fetch at address+1, wrapping 2^ADDR_BITS-1 → 0.
  - On the other falls, shift left and drive the next bit.
  - spi_miso_oe=1 from the first data fall until CSN rises.
  - First data bit timing: driven on the fall following the last ADDR rise (0x03) or the last DUMMY rise (0x0B).
- Prefetch:
  - One byte buffer and one outstanding request.
  - mem_ack fills the buffer and drops mem_req on the next clock.
  - The buffer is consumed at the byte load.
  - If the buffer is empty at a byte load: shift in 0xFF, set underrun, still advance the address, and keep the current request.
- IGNORE: MISO is not driven; wait for CSN high.
- CSN rise in any state:
  - Next clock: state=IDLE, spi_miso_oe=0, spi_miso=0, active=0. A partial byte is discarded.
  - An outstanding mem_req stays high until its mem_ack; that data is discarded.
  - A new transaction may start while that discard is pending. Its first fetch waits for the pending ack.
- Simultaneous CSN rise and SCK edge in the same synced cycle: CSN wins and the edge is ignored.
- Fewer than 8 command bits, or a truncated address: no fetch; return to IDLE.

Test Plan:
1. Memory returns (addr[7:0]^0xA5); send 0x03, 0x000010, read 4 bytes → MISO bytes 0xB5,0xB4,0xB7,0xB6; mem_addr 0x10..0x14 in order; last_cmd=0x03; underrun=0.
2. Send 0x0B, 0x200000, one dummy byte, read 2 bytes → 0xA5,0xA4; spi_miso_oe stays 0 during the dummy byte.
3. Send 0x03, 0xFFFFFE, read 3 bytes → addresses 0xFFFFFE, 0xFFFFFF, 0x000000; data 0x5B,0x5A,0xA5.
4. Send 0x9F then 16 clocks → no mem_req; spi_miso_oe=0 throughout; last_cmd=0x9F; active drops one synced cycle after CSN rises.
5. mem_ack delayed 40 clocks with SCK half-period 6 clocks → first byte reads 0xFF; underrun=1, and stays 1 until reset.
6. CSN raised after 3 data bits, then reset asserted mid-command on a second transaction → IDLE; spi_miso_oe=0; mem_req=0 after reset; all outputs at reset values.
